// File: rtl/modulator_cfg_master.sv
// modulator_cfg_master: AXI4-Lite write-only master that programs the PWM
// modulator after reset and then keeps its frequency-select register (0x0)
// up to date.
//
// Init sequence: 0x4 <- DIV_HIGH_P, 0x8 <- DIV_LOW_P, 0x0 <- 0.
// Run phase: 0x0 is rewritten from sel_i whenever it differs from the last
// acknowledged value, or, with MODCFG_AUTO_TOGGLE_EN defined, toggled every
// SW_PERIOD_P cycles spent idle (sel_i is then ignored).
//
// Ports:
//   m00_axi_aclk / m00_axi_aresetn : clock, async active-low reset
//   m00_axi_aw* / m00_axi_w*       : write address / write data channels
//   m00_axi_b*                     : write response channel
//   sel_i      : requested sw0 value (default build only)
//   cfg_done_o : init sequence complete (sticky)
//   cfg_err_o  : some write response was not OKAY (sticky)
//   sw0_o      : last sw0 value acknowledged by the slave
//   busy_o     : a write is outstanding
module modulator_cfg_master #(
  parameter int unsigned DIV_HIGH_P  = 12288,
  parameter int unsigned DIV_LOW_P   = 40960,
  parameter int unsigned SW_PERIOD_P = 10000000
) (
  input  logic        m00_axi_aclk,
  input  logic        m00_axi_aresetn,
  output logic [3:0]  m00_axi_awaddr,
  output logic [2:0]  m00_axi_awprot,
  output logic        m00_axi_awvalid,
  input  logic        m00_axi_awready,
  output logic [31:0] m00_axi_wdata,
  output logic [3:0]  m00_axi_wstrb,
  output logic        m00_axi_wvalid,
  input  logic        m00_axi_wready,
  input  logic [1:0]  m00_axi_bresp,
  input  logic        m00_axi_bvalid,
  output logic        m00_axi_bready,
  input  logic        sel_i,
  output logic        cfg_done_o,
  output logic        cfg_err_o,
  output logic        sw0_o,
  output logic        busy_o
);

  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned IDX_W  = 2;

  typedef enum logic [1:0] {
    S_LOAD,
    S_AW_W,
    S_B,
    S_RUN
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [IDX_W-1:0]    r_idx, w_idx_nxt;
  logic [ADDR_W-1:0]   r_awaddr, w_awaddr_nxt;
  logic [DATA_W-1:0]   r_wdata, w_wdata_nxt;
  logic                r_awvalid, w_awvalid_nxt;
  logic                r_wvalid, w_wvalid_nxt;
  logic                r_aw_done, w_aw_done_nxt;
  logic                r_w_done, w_w_done_nxt;
  logic                r_bready, w_bready_nxt;
  logic                r_cfg_done, w_cfg_done_nxt;
  logic                r_cfg_err, w_cfg_err_nxt;
  logic                r_sw0, w_sw0_nxt;
  logic                r_busy, w_busy_nxt;
  logic                w_trig;
  logic                w_trig_val;

`ifdef MODCFG_AUTO_TOGGLE_EN
  localparam logic [31:0] CNT_LAST = 32'(SW_PERIOD_P - 1);
  logic [31:0] r_cnt, w_cnt_nxt;
  logic        w_unused_sel;
  assign w_unused_sel = sel_i;
`else
  logic        w_unused_period;
  assign w_unused_period = (SW_PERIOD_P >= 2);
`endif

  // State and output registers
  always_ff @(posedge m00_axi_aclk or negedge m00_axi_aresetn) begin
    if (!m00_axi_aresetn) begin
      r_state    <= S_LOAD;
      r_idx      <= '0;
      r_awaddr   <= '0;
      r_wdata    <= '0;
      r_awvalid  <= 1'b0;
      r_wvalid   <= 1'b0;
      r_aw_done  <= 1'b0;
      r_w_done   <= 1'b0;
      r_bready   <= 1'b0;
      r_cfg_done <= 1'b0;
      r_cfg_err  <= 1'b0;
      r_sw0      <= 1'b0;
      r_busy     <= 1'b0;
`ifdef MODCFG_AUTO_TOGGLE_EN
      r_cnt      <= '0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_idx      <= w_idx_nxt;
      r_awaddr   <= w_awaddr_nxt;
      r_wdata    <= w_wdata_nxt;
      r_awvalid  <= w_awvalid_nxt;
      r_wvalid   <= w_wvalid_nxt;
      r_aw_done  <= w_aw_done_nxt;
      r_w_done   <= w_w_done_nxt;
      r_bready   <= w_bready_nxt;
      r_cfg_done <= w_cfg_done_nxt;
      r_cfg_err  <= w_cfg_err_nxt;
      r_sw0      <= w_sw0_nxt;
      r_busy     <= w_busy_nxt;
`ifdef MODCFG_AUTO_TOGGLE_EN
      r_cnt      <= w_cnt_nxt;
`endif
    end
  end

  // Run-time write trigger: toggle timer or sel_i mismatch
  always_comb begin
    w_trig     = 1'b0;
    w_trig_val = 1'b0;
`ifdef MODCFG_AUTO_TOGGLE_EN
    w_cnt_nxt  = r_cnt;
    if (r_state == S_RUN) begin
      if (r_cnt == CNT_LAST) begin
        w_trig     = 1'b1;
        w_trig_val = ~r_sw0;
      end else begin
        w_cnt_nxt = r_cnt + 32'd1;
      end
    end
    // Clear on every entry into S_RUN
    if ((r_state == S_B) && m00_axi_bvalid && (r_cfg_done || (r_idx == IDX_W'(2)))) begin
      w_cnt_nxt = '0;
    end
`else
    if ((r_state == S_RUN) && (sel_i != r_sw0)) begin
      w_trig     = 1'b1;
      w_trig_val = sel_i;
    end
`endif
  end

  // Next-state and registered-output logic
  always_comb begin
    w_state_nxt    = r_state;
    w_idx_nxt      = r_idx;
    w_awaddr_nxt   = r_awaddr;
    w_wdata_nxt    = r_wdata;
    w_awvalid_nxt  = r_awvalid;
    w_wvalid_nxt   = r_wvalid;
    w_aw_done_nxt  = r_aw_done;
    w_w_done_nxt   = r_w_done;
    w_bready_nxt   = r_bready;
    w_cfg_done_nxt = r_cfg_done;
    w_cfg_err_nxt  = r_cfg_err;
    w_sw0_nxt      = r_sw0;

    unique case (r_state)
      S_LOAD: begin
        unique case (r_idx)
          IDX_W'(0): begin
            w_awaddr_nxt = ADDR_W'(4'h4);
            w_wdata_nxt  = DATA_W'(DIV_HIGH_P);
          end
          IDX_W'(1): begin
            w_awaddr_nxt = ADDR_W'(4'h8);
            w_wdata_nxt  = DATA_W'(DIV_LOW_P);
          end
          default: begin
            w_awaddr_nxt = '0;
            w_wdata_nxt  = '0;
          end
        endcase
        w_aw_done_nxt = 1'b0;
        w_w_done_nxt  = 1'b0;
        w_state_nxt   = S_AW_W;
      end

      S_AW_W: begin
        // Each channel raises valid once, then drops it for good after its handshake
        if (!r_aw_done) begin
          if (r_awvalid && m00_axi_awready) begin
            w_awvalid_nxt = 1'b0;
            w_aw_done_nxt = 1'b1;
          end else begin
            w_awvalid_nxt = 1'b1;
          end
        end
        if (!r_w_done) begin
          if (r_wvalid && m00_axi_wready) begin
            w_wvalid_nxt = 1'b0;
            w_w_done_nxt = 1'b1;
          end else begin
            w_wvalid_nxt = 1'b1;
          end
        end
        if (w_aw_done_nxt && w_w_done_nxt) begin
          w_bready_nxt = 1'b1;
          w_state_nxt  = S_B;
        end
      end

      S_B: begin
        if (m00_axi_bvalid) begin
          w_bready_nxt = 1'b0;
          if (m00_axi_bresp != 2'b00) begin
            w_cfg_err_nxt = 1'b1;
          end
          if (r_awaddr == '0) begin
            w_sw0_nxt = r_wdata[0];
          end
          if (r_cfg_done || (r_idx == IDX_W'(2))) begin
            w_cfg_done_nxt = 1'b1;
            w_state_nxt    = S_RUN;
          end else begin
            w_idx_nxt   = r_idx + IDX_W'(1);
            w_state_nxt = S_LOAD;
          end
        end
      end

      S_RUN: begin
        if (w_trig) begin
          w_awaddr_nxt  = '0;
          w_wdata_nxt   = {31'b0, w_trig_val};
          w_aw_done_nxt = 1'b0;
          w_w_done_nxt  = 1'b0;
          w_state_nxt   = S_AW_W;
        end
      end

      default: begin
        w_state_nxt = S_LOAD;
      end
    endcase

    w_busy_nxt = (w_state_nxt == S_AW_W) || (w_state_nxt == S_B);
  end

  assign m00_axi_awaddr  = r_awaddr;
  assign m00_axi_awprot  = 3'b000;
  assign m00_axi_awvalid = r_awvalid;
  assign m00_axi_wdata   = r_wdata;
  assign m00_axi_wstrb   = r_wvalid ? 4'hF : 4'h0;
  assign m00_axi_wvalid  = r_wvalid;
  assign m00_axi_bready  = r_bready;
  assign cfg_done_o      = r_cfg_done;
  assign cfg_err_o       = r_cfg_err;
  assign sw0_o           = r_sw0;
  assign busy_o          = r_busy;

endmodule

// File: tb/tb_modulator_cfg_master.sv
// Bench for modulator_cfg_master: AXI4-Lite slave responder with
// programmable ready/response delays, write log, and directed plus
// randomized checks against an expected-transaction model.
module tb_modulator_cfg_master;

  localparam int unsigned P        = 100;
  localparam logic [31:0] DIV_HIGH = 32'd12288;
  localparam logic [31:0] DIV_LOW  = 32'd40960;

  logic        clk;
  logic        aresetn;
  logic [3:0]  awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic        sel_i;
  logic        cfg_done_o;
  logic        cfg_err_o;
  logic        sw0_o;
  logic        busy_o;

  modulator_cfg_master #(
    .DIV_HIGH_P (12288),
    .DIV_LOW_P  (40960),
    .SW_PERIOD_P(P)
  ) dut (
    .m00_axi_aclk   (clk),
    .m00_axi_aresetn(aresetn),
    .m00_axi_awaddr (awaddr),
    .m00_axi_awprot (awprot),
    .m00_axi_awvalid(awvalid),
    .m00_axi_awready(awready),
    .m00_axi_wdata  (wdata),
    .m00_axi_wstrb  (wstrb),
    .m00_axi_wvalid (wvalid),
    .m00_axi_wready (wready),
    .m00_axi_bresp  (bresp),
    .m00_axi_bvalid (bvalid),
    .m00_axi_bready (bready),
    .sel_i          (sel_i),
    .cfg_done_o     (cfg_done_o),
    .cfg_err_o      (cfg_err_o),
    .sw0_o          (sw0_o),
    .busy_o         (busy_o)
  );

  typedef struct packed {
    logic [3:0]  a;
    logic [31:0] d;
    logic [3:0]  s;
    logic [1:0]  r;
  } wr_t;

  wr_t         log_q[$];
  int          rise_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          aw_delay = 0, w_delay = 0, b_delay = 0;
  logic [3:0]  err_addr = 4'hF;
  int          aw_hs = 0, w_hs = 0, b_hs = 0;

  // slave-side transaction state
  int          aw_cnt, w_cnt, b_cnt;
  logic        aw_got, w_got, prev_awv;
  logic [3:0]  cur_a, cur_s;
  logic [31:0] cur_d;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Slave responder: evaluates on the falling edge, handshakes land on the next rising edge
  initial begin
    wr_t e;
    awready = 0; wready = 0; bvalid = 0; bresp = 0;
    aw_cnt = 0; w_cnt = 0; b_cnt = 0; aw_got = 0; w_got = 0; prev_awv = 0;
    cur_a = 0; cur_s = 0; cur_d = 0;
    forever begin
      @(negedge clk);
      if (!aresetn) begin
        awready = 0; wready = 0; bvalid = 0; bresp = 0;
        aw_cnt = 0; w_cnt = 0; b_cnt = 0; aw_got = 0; w_got = 0; prev_awv = 0;
      end else begin
        if (awvalid && !prev_awv) rise_q.push_back(cyc);
        prev_awv = awvalid;
        awready = awvalid && (aw_cnt >= aw_delay);
        if (awvalid && !awready) aw_cnt++;
        if (awready) begin aw_got = 1; cur_a = awaddr; aw_cnt = 0; aw_hs++; end
        wready = wvalid && (w_cnt >= w_delay);
        if (wvalid && !wready) w_cnt++;
        if (wready) begin w_got = 1; cur_d = wdata; cur_s = wstrb; w_cnt = 0; w_hs++; end
        bvalid = bready && aw_got && w_got && (b_cnt >= b_delay);
        if (bready && aw_got && w_got && !bvalid) b_cnt++;
        if (bvalid) begin
          bresp = (cur_a == err_addr) ? 2'b10 : 2'b00;
          e.a = cur_a; e.d = cur_d; e.s = cur_s; e.r = bresp;
          log_q.push_back(e);
          aw_got = 0; w_got = 0; b_cnt = 0; b_hs++;
        end else begin
          bresp = 2'b00;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string t);
    check({t, "_awvalid"}, 32'(awvalid), 32'd0);
    check({t, "_wvalid"},  32'(wvalid), 32'd0);
    check({t, "_bready"},  32'(bready), 32'd0);
    check({t, "_awaddr"},  32'(awaddr), 32'd0);
    check({t, "_wdata"},   wdata, 32'd0);
    check({t, "_wstrb"},   32'(wstrb), 32'd0);
    check({t, "_awprot"},  32'(awprot), 32'd0);
    check({t, "_done"},    32'(cfg_done_o), 32'd0);
    check({t, "_err"},     32'(cfg_err_o), 32'd0);
    check({t, "_sw0"},     32'(sw0_o), 32'd0);
    check({t, "_busy"},    32'(busy_o), 32'd0);
  endtask

  task automatic do_reset(input string t);
    sel_i = 1'b0;
    aresetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero(t);
    log_q.delete();
    rise_q.delete();
    aw_hs = 0; w_hs = 0; b_hs = 0;
    @(negedge clk);
    aresetn = 1'b1;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (cfg_done_o !== 1'b1 && n < 60) begin
      @(posedge clk); #1; n++;
    end
  endtask

  task automatic wait_idle(input string t);
    int n;
    n = 0;
    repeat (3) begin @(posedge clk); #1; end
    while ((busy_o !== 1'b0 || sw0_o !== sel_i) && n < 100) begin
      @(posedge clk); #1; n++;
    end
    check({t, "_idle_in_time"}, 32'(n < 100), 32'd1);
  endtask

  // Expected init writes, in order
  task automatic check_init(input string t);
    logic [3:0]  ea [3];
    logic [31:0] ed [3];
    ea[0] = 4'h4; ea[1] = 4'h8; ea[2] = 4'h0;
    ed[0] = DIV_HIGH; ed[1] = DIV_LOW; ed[2] = 32'd0;
    check({t, "_nwrites"}, 32'(log_q.size()), 32'd3);
    for (int i = 0; i < 3 && i < log_q.size(); i++) begin
      check($sformatf("%s_addr%0d", t, i), 32'(log_q[i].a), 32'(ea[i]));
      check($sformatf("%s_data%0d", t, i), log_q[i].d, ed[i]);
      check($sformatf("%s_strb%0d", t, i), 32'(log_q[i].s), 32'hF);
    end
  endtask

  initial begin
    int n;
    int base;
    int exp_n;
    logic m_sw0;
    logic s;
    aresetn = 1'b0;
    sel_i = 1'b0;

    // 1: zero-wait slave, reset release
    do_reset("rst0");
    wait_done(n);
    check("init_latency_le14", 32'(n <= 14), 32'd1);
    check_init("init0");
    check("init0_err", 32'(cfg_err_o), 32'd0);
    check("init0_sw0", 32'(sw0_o), 32'd0);
    check("init0_bcount", 32'(b_hs), 32'd3);

`ifdef MODCFG_AUTO_TOGGLE_EN
    // 2: auto toggle writes 1,0,1 spaced by the period plus transfer cycles
    base = rise_q.size();
    n = 0;
    while (log_q.size() < 6 && n < 600) begin @(posedge clk); #1; n++; end
    check("tog_nwrites", 32'(log_q.size()), 32'd6);
    m_sw0 = 1'b0;
    for (int i = 3; i < 6 && i < log_q.size(); i++) begin
      m_sw0 = ~m_sw0;
      check($sformatf("tog_addr%0d", i), 32'(log_q[i].a), 32'd0);
      check($sformatf("tog_data%0d", i), log_q[i].d, 32'(m_sw0));
    end
    if (rise_q.size() >= base + 3) begin
      check("tog_space1", 32'(rise_q[base+1] - rise_q[base]), 32'(P + 3));
      check("tog_space2", 32'(rise_q[base+2] - rise_q[base+1]), 32'(P + 3));
    end else begin
      check("tog_rises", 32'(rise_q.size() - base), 32'd3);
    end
    @(posedge clk); #1;
    check("tog_sw0", 32'(sw0_o), 32'd1);
`else
    // 2: sel_i rise, then fall during the write
    repeat (2) begin @(posedge clk); #1; end
    check("sel_idle_busy", 32'(busy_o), 32'd0);
    sel_i = 1'b1;
    @(posedge clk); #1;
    check("sel_busy", 32'(busy_o), 32'd1);
    @(posedge clk); #1;
    check("sel_awvalid_2cyc", 32'(awvalid), 32'd1);
    check("sel_awaddr", 32'(awaddr), 32'd0);
    check("sel_wdata", wdata, 32'd1);
    sel_i = 1'b0;
    wait_idle("sel");
    check("sel_nwrites", 32'(log_q.size()), 32'd5);
    if (log_q.size() >= 5) begin
      check("sel_w1", log_q[3].d, 32'd1);
      check("sel_w2", log_q[4].d, 32'd0);
      check("sel_w2_addr", 32'(log_q[4].a), 32'd0);
    end
    check("sel_sw0", 32'(sw0_o), 32'd0);

    // 3: randomized sel_i changes with random slave latencies
    m_sw0 = 1'b0;
    for (int it = 0; it < 16; it++) begin
      aw_delay = int'($urandom_range(0, 3));
      w_delay  = int'($urandom_range(0, 3));
      b_delay  = int'($urandom_range(0, 3));
      s = 1'($urandom_range(0, 1));
      base = log_q.size();
      exp_n = (s != m_sw0) ? 1 : 0;
      sel_i = s;
      wait_idle($sformatf("rnd%0d", it));
      check($sformatf("rnd%0d_sw0", it), 32'(sw0_o), 32'(s));
      check($sformatf("rnd%0d_nw", it), 32'(log_q.size() - base), 32'(exp_n));
      if (exp_n == 1 && log_q.size() > base) begin
        check($sformatf("rnd%0d_data", it), log_q[base].d, 32'(s));
      end
      m_sw0 = s;
    end
    check("rnd_hs_match", 32'(aw_hs == w_hs && w_hs == b_hs), 32'd1);
    aw_delay = 0; w_delay = 0; b_delay = 0;
`endif

    // 4: SLVERR on the 0x8 write
    err_addr = 4'h8;
    do_reset("rst_err");
    wait_done(n);
    check("err_done", 32'(cfg_done_o), 32'd1);
    check("err_flag", 32'(cfg_err_o), 32'd1);
    check_init("err");
    repeat (5) @(posedge clk);
    #1;
    check("err_sticky", 32'(cfg_err_o), 32'd1);
    err_addr = 4'hF;

    // 5: awready delayed 3 cycles, wready immediate
    aw_delay = 3;
    do_reset("rst_aw");
    n = 0;
    while (awvalid !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    check("awd_wvalid_with_aw", 32'(wvalid), 32'd1);
    @(posedge clk); #1;
    check("awd_wvalid_drop", 32'(wvalid), 32'd0);
    check("awd_awvalid_hold", 32'(awvalid), 32'd1);
    wait_done(n);
    check("awd_done", 32'(cfg_done_o), 32'd1);
    check_init("awd");
    check("awd_aw_hs", 32'(aw_hs), 32'd3);
    check("awd_w_hs", 32'(w_hs), 32'd3);
    check("awd_b_hs", 32'(b_hs), 32'd3);

    // 6: reset asserted while awvalid is high
    aw_delay = 6;
`ifndef MODCFG_AUTO_TOGGLE_EN
    sel_i = 1'b1;
`endif
    n = 0;
    while (awvalid !== 1'b1 && n < 300) begin @(posedge clk); #1; n++; end
    check("mid_awvalid_seen", 32'(awvalid), 32'd1);
    #1 aresetn = 1'b0;
    #1;
    check_all_zero("mid_rst");
    aw_delay = 0;
    do_reset("rst_mid");
    wait_done(n);
    check("mid_done", 32'(cfg_done_o), 32'd1);
    check_init("mid");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/modulator_cfg_master.md
# modulator_cfg_master

AXI4-Lite master that configures and sequences the PWM modulator AXI IP without a processor. After reset it writes the two frequency divider factors and the frequency-select bit. It then keeps the select register updated, either from an external input or from an internal toggle timer. It connects directly to the modulator's `s00_axi` write channels; the read channels are tied off at the top level.

## Interface
- `DIV_HIGH_P`, 12288: divider factor written to 0x4 (high frequency).
- `DIV_LOW_P`, 40960: divider factor written to 0x8 (low frequency).
- `SW_PERIOD_P`, 10000000: clock cycles between automatic sw0 toggles; must be ≥ 2 (used only with the macro).

Ports:
- `m00_axi_aclk` in 1: single clock.
- `m00_axi_aresetn` in 1: reset, asynchronous, active-low.
- `m00_axi_awaddr` out 4: write address.
- `m00_axi_awprot` out 3: constant 3'b000.
- `m00_axi_awvalid` out 1, `m00_axi_awready` in 1.
- `m00_axi_wdata` out 32: write data.
- `m00_axi_wstrb` out 4: 4'hF while `wvalid` is high, else 4'h0.
- `m00_axi_wvalid` out 1, `m00_axi_wready` in 1.
- `m00_axi_bresp` in 2, `m00_axi_bvalid` in 1, `m00_axi_bready` out 1.
- `sel_i` in 1: requested sw0 value (used only without the macro).
- `cfg_done_o` out 1: init sequence complete; sticky until reset.
- `cfg_err_o` out 1: sticky; set when any `bresp` ≠ 2'b00.
- `sw0_o` out 1: last sw0 value acknowledged by the slave.
- `busy_o` out 1: high while a write is outstanding.

## Operation
- Reset values: every output is 0, state is S_LOAD, write index is 0, toggle counter is 0.
- States and transitions:
  - S_LOAD: selects the next write, then moves to S_AW_W.
  - S_AW_W: drives `awvalid` and `wvalid`. Moves to S_B once both handshakes are done.
  - S_B: drives `bready`. On `bvalid`, returns to S_LOAD during init, or to S_RUN after init.
  - S_RUN: waits for a write trigger, then moves to S_AW_W.
- Init sequence, in fixed order:
  - 0x4 ← `DIV_HIGH_P`
  - 0x8 ← `DIV_LOW_P`
  - 0x0 ← 0
- `cfg_done_o` rises in the cycle after the third B handshake. The state then enters S_RUN.
- S_AW_W behaviour:
  - `awvalid` and `wvalid` assert together and each is held independently until its own ready is sampled high.
  - `awaddr` and `wdata` stay stable while their valid is high.
  - If AW and W complete in different cycles, the completed channel's valid is low and stays low.
- S_B: `bready` is high until `bvalid` is sampled. On that cycle:
  - `bresp` is checked;
  - if `bresp` ≠ 2'b00, `cfg_err_o` is set;
  - `sw0_o` updates for 0x0 writes, regardless of `bresp`.
- An error never stalls the sequence.
- Run-time trigger in S_RUN:
  - without the macro, `sel_i` ≠ `sw0_o`: write 0x0 ← {31'b0, `sel_i`};
  - with the macro, the toggle timer expires: write 0x0 ← {31'b0, ~`sw0_o`}.
- `sel_i` changes while busy are not queued. The comparison is re-evaluated on return to S_RUN.
- `busy_o` = (state ∈ {S_AW_W, S_B}).

## Timing
- Valid outputs are registered:
  - `awvalid`/`wvalid` go high 1 cycle after entering S_AW_W;
  - each drops 1 cycle after its ready is sampled high.
- Minimum write cost is 4 cycles with zero-wait slave ready and B response (S_LOAD/S_RUN, S_AW_W, handshake cycle, S_B).
- Init with a zero-wait slave completes in ≤ 14 cycles after reset release.
- Toggle counter (32-bit):
  - clears on entry to S_RUN and counts while in S_RUN;
  - expires at `SW_PERIOD_P`−1, so the next write starts `SW_PERIOD_P` cycles after entry.
- Reset asserted mid-operation:
  - all outputs drop to 0 asynchronously, abandoning the outstanding transaction;
  - after release, init restarts from 0x4.

## Configuration
- Macro: `MODCFG_AUTO_TOGGLE_EN`.
- When defined:
  - the toggle timer is compiled in and sw0 alternates every `SW_PERIOD_P` cycles of S_RUN;
  - `sel_i` is ignored.
- When undefined:
  - there is no timer logic;
  - sw0 is written only at init and when `sel_i` ≠ `sw0_o`.

## Test plan
- **Zero-wait slave, reset release:** exactly three writes occur, in order:
  - (0x4, 12288), (0x8, 40960), (0x0, 0);
  - `wstrb` = 4'hF on each;
  - `cfg_done_o` = 1 ≤ 14 cycles after release; `cfg_err_o` = 0.
- **`awready` delayed 3 cycles, `wready` immediate:**
  - `wvalid` drops after 1 cycle while `awvalid` holds;
  - one B handshake per write; no duplicate writes.
- **Slave returns `bresp` = 2'b10 on the 0x8 write:**
  - `cfg_err_o` = 1 and stays 1;
  - the 0x0 write is still issued and `cfg_done_o` = 1.
- **Macro defined, `SW_PERIOD_P` = 100:**
  - after init, 0x0 writes carry data 1, 0, 1;
  - the `awvalid` rising edges are spaced 100 + write cost cycles apart.
- **Macro undefined:**
  - `sel_i` 0→1 in S_RUN: `awvalid` high 2 cycles later with (0x0, 1);
  - `sel_i` returns to 0 during that write: a second write (0x0, 0) follows its completion, and `sw0_o` ends at 0.
- **`m00_axi_aresetn` low while `awvalid` = 1:**
  - all outputs are 0 the same cycle;
  - after release, the first write is again (0x4, 12288).
